des_key_sched: RTL and testbench
================================

# des_key_sched

DES key-schedule generator. It accepts one 64-bit key and emits the 16 round subkeys (48 bits each), one per handshake, in encrypt order (K1..K16) or decrypt order (K16..K1). It sits upstream of the expansion/key-XOR stage; that stage combines each subkey with E(R) to form the 48-bit word consumed by the S-box compression stage. Bit convention across the datapath: vector index n carries FIPS 46-3 bit n+1, so index 0 is the first DES bit.

## Interface
Parameters:
- CHECK_PARITY, 1: 1 enables the odd-parity check on key bytes; 0 ties parity_err_out to 0.

Ports:
- clk_in  input  1  clock
- rst_n_in  input  1  reset, asynchronous, active-low
- key_in  input  64  key in DES bit order; parity bits (FIPS 8,16,…,64) are excluded from subkeys
- key_in_valid  input  1  key offered
- decrypt_in  input  1  order select, sampled with key: 0 = K1..K16, 1 = K16..K1
- key_in_ready  output  1  block idle and able to accept a key
- subkey_out  output  48  current round subkey, DES bit order (PC-2 output)
- subkey_out_valid  output  1  subkey_out is valid
- subkey_out_ready  input  1  consumer accepts subkey
- subkey_round_out  output  4  output index 0..15 (the position in emission order, not the K number)
- subkey_last_out  output  1  high with valid on index 15
- parity_err_out  output  1  latched at key acceptance: at least one key byte has even parity

## Operation
- States: IDLE and RUN. key_in_ready = (state == IDLE), combinational.
- Key accept: key_in_valid & key_in_ready at an edge.
  - C/D registers (28 bits each) ← PC-1(key_in), then rotated: encrypt rotates left by 1; decrypt applies no rotation (C16 = C0).
  - decrypt_in is latched.
  - subkey_out ← PC-2 of the new C/D; subkey_out_valid ← 1; round ← 0.
  - parity_err_out is updated.
  - State → RUN.
- Advance on handshake (subkey_out_valid & subkey_out_ready):
  - If round == 15: valid ← 0, state → IDLE. subkey_out, round and parity_err_out hold their last values.
  - Otherwise: round ← round+1; C/D rotate; subkey_out ← PC-2 of the rotated C/D.
- Rotation amounts:
  - Encrypt, producing Kr: rotate left by SHIFT[r] = 1 for r ∈ {1,2,9,16}, else 2.
  - Decrypt, producing index j (1..15): rotate right by SHIFT[17-j]. The resulting right-shift sequence is 1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
- Without a handshake, subkey_out, round and valid hold. Values must not change while valid & !ready.
- Key inputs in RUN are ignored (key_in_ready = 0). There is no back-to-back acceptance on the last handshake edge; the new key is accepted no earlier than the following edge.
- Parity: parity_err_out = OR over the 8 bytes of (XNOR of the byte's bits). This flag is informational only and does not stop subkey generation.

## Timing
- Reset values (asynchronous, take effect immediately):
  - state IDLE, so key_in_ready = 1
  - subkey_out 0, subkey_out_valid 0, subkey_round_out 0, subkey_last_out 0, parity_err_out 0
  - C/D = 0
- Latency: the first subkey is valid in the cycle after key acceptance (1 cycle).
- Throughput: 1 subkey per cycle with ready held high. A full key takes 16 cycles in RUN; the next key can be accepted 17 cycles after the previous acceptance.
- subkey_last_out = subkey_out_valid & (round == 15), registered-equivalent (no combinational path from inputs).
- Reset mid-RUN: valid drops immediately and the sequence is abandoned. After reset release the block is IDLE and needs a fresh key.
- Round counter wrap: the counter never increments past 15; the handshake at 15 ends the run.

## Structure
- Package des_pkg:
  - PC1_TABLE[56] and PC2_TABLE[48] index constants (0-based DES order)
  - SHIFT_SCHED[16]
  - typedefs des_half_t (logic [27:0]) and des_subkey_t (logic [47:0])
  - state enum {IDLE, RUN}
- One natural sub-module: des_key_pc2, a combinational mapping from {C,D} (56 bits) to a 48-bit subkey. It is instantiated once, on the next-C/D value.
- The remainder (PC-1, rotation mux, counter, handshake, parity) lives in the top.

## Test plan
Keys and subkeys below are in FIPS order, with the first hex digit's MSB at index 0.

- Encrypt, ready held 1: key 133457799BBCDFF1, decrypt 0.
  - Index 0 = 1B02EFFC7072, index 15 = CB3D8B0E17F5.
  - Valid is high for 16 consecutive cycles; last is high only on index 15; parity_err 0.
- Decrypt, same key: index 0 = CB3D8B0E17F5, index 15 = 1B02EFFC7072. The full sequence equals the encrypt run reversed.
- Backpressure: ready dropped for 3 cycles while index 4 is presented. subkey_out and round stay at index 4; the sequence resumes with no skipped or duplicated subkey.
- Parity: key 133457799BBCDFF0 gives parity_err_out = 1 with CHECK_PARITY = 1, and 0 with CHECK_PARITY = 0.
  - Subkeys are identical to the first scenario, because the parity bit is ignored.
- Busy and boundaries:
  - key_in_valid pulsed during RUN is ignored.
  - After the last handshake, key_in_ready = 1 the next cycle, and a second key is accepted and sequenced correctly.
- Reset at index 7: valid = 0 and key_in_ready = 1 immediately. A new key restarts from index 0.

Source files
------------

// File: rtl/des_pkg.sv
// Shared DES key-schedule constants and types. Table entries are 0-based
// indices in DES bit order (index 0 is the first DES bit).
package des_pkg;

    typedef logic [27:0] des_half_t;
    typedef logic [47:0] des_subkey_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int unsigned PC1_TABLE [56] = '{
        56, 48, 40, 32, 24, 16,  8,
         0, 57, 49, 41, 33, 25, 17,
         9,  1, 58, 50, 42, 34, 26,
        18, 10,  2, 59, 51, 43, 35,
        62, 54, 46, 38, 30, 22, 14,
         6, 61, 53, 45, 37, 29, 21,
        13,  5, 60, 52, 44, 36, 28,
        20, 12,  4, 27, 19, 11,  3
    };

    localparam int unsigned PC2_TABLE [48] = '{
        13, 16, 10, 23,  0,  4,
         2, 27, 14,  5, 20,  9,
        22, 18, 11,  3, 25,  7,
        15,  6, 26, 19, 12,  1,
        40, 51, 30, 36, 46, 54,
        29, 39, 50, 44, 32, 47,
        43, 48, 38, 55, 33, 52,
        45, 41, 49, 35, 28, 31
    };

    // Left-rotation amount used to produce round k+1 in encrypt order.
    localparam int unsigned SHIFT_SCHED [16] = '{
        1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1
    };

    // Index 0 is the first DES bit, so a DES left rotation moves bit 0 to the top.
    function automatic des_half_t des_rotl(input des_half_t x, input logic two);
        return two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
    endfunction

    function automatic des_half_t des_rotr(input des_half_t x, input logic two);
        return two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
    endfunction

endpackage

// File: rtl/des_key_pc2.sv
// Permuted Choice 2: selects 48 of the 56 C/D bits to form one round subkey.
module des_key_pc2
    import des_pkg::*;
(
    input  logic [55:0] cd,
    output logic [47:0] subkey
);

    for (genvar gi = 0; gi < 48; gi++) begin : g_pc2
        assign subkey[gi] = cd[PC2_TABLE[gi]];
    end

endmodule

// File: rtl/des_key_sched.sv
// DES key-schedule generator: one 64-bit key in, 16 round subkeys out over a
// valid/ready handshake, in encrypt (K1..K16) or decrypt (K16..K1) order.
module des_key_sched
    import des_pkg::*;
#(
    parameter bit CHECK_PARITY = 1'b1
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic [63:0] key_in,
    input  logic        key_in_valid,
    input  logic        decrypt_in,
    output logic        key_in_ready,
    output logic [47:0] subkey_out,
    output logic        subkey_out_valid,
    input  logic        subkey_out_ready,
    output logic [3:0]  subkey_round_out,
    output logic        subkey_last_out,
    output logic        parity_err_out
);

    state_t      state_reg;
    des_half_t   c_reg, d_reg;
    des_half_t   c_next, d_next;
    des_subkey_t subkey_reg, subkey_next;
    logic [3:0]  round_reg;
    logic        valid_reg, last_reg, decrypt_reg, parity_reg;

    logic [55:0] pc1_key;
    logic [15:0] shift_two;
    logic [7:0]  byte_even;
    logic [3:0]  shift_idx;
    logic        parity_err, accept, advance;

    for (genvar gi = 0; gi < 56; gi++) begin : g_pc1
        assign pc1_key[gi] = key_in[PC1_TABLE[gi]];
    end

    for (genvar gi = 0; gi < 16; gi++) begin : g_shift
        assign shift_two[gi] = (SHIFT_SCHED[gi] == 2);
    end

    for (genvar gi = 0; gi < 8; gi++) begin : g_parity
        assign byte_even[gi] = ~^key_in[8*gi +: 8];
    end
    assign parity_err = CHECK_PARITY && (|byte_even);

    assign accept  = key_in_valid && (state_reg == IDLE);
    assign advance = subkey_out_valid && subkey_out_ready;

    // Decrypt walks the schedule backwards: index j undoes the shift of round 17-j.
    assign shift_idx = decrypt_reg ? ~round_reg : round_reg + 4'd1;

    always_comb begin
        c_next = c_reg;
        d_next = d_reg;
        if (accept) begin
            c_next = decrypt_in ? pc1_key[27:0]  : des_rotl(pc1_key[27:0], 1'b0);
            d_next = decrypt_in ? pc1_key[55:28] : des_rotl(pc1_key[55:28], 1'b0);
        end else if (advance && round_reg != 4'd15) begin
            if (decrypt_reg) begin
                c_next = des_rotr(c_reg, shift_two[shift_idx]);
                d_next = des_rotr(d_reg, shift_two[shift_idx]);
            end else begin
                c_next = des_rotl(c_reg, shift_two[shift_idx]);
                d_next = des_rotl(d_reg, shift_two[shift_idx]);
            end
        end
    end

    des_key_pc2 u_pc2 (
        .cd     ({d_next, c_next}),
        .subkey (subkey_next)
    );

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_reg   <= IDLE;
            c_reg       <= '0;
            d_reg       <= '0;
            subkey_reg  <= '0;
            round_reg   <= '0;
            valid_reg   <= 1'b0;
            last_reg    <= 1'b0;
            decrypt_reg <= 1'b0;
            parity_reg  <= 1'b0;
        end else begin
            c_reg <= c_next;
            d_reg <= d_next;
            case (state_reg)
                IDLE: begin
                    if (key_in_valid) begin
                        state_reg   <= RUN;
                        subkey_reg  <= subkey_next;
                        round_reg   <= '0;
                        valid_reg   <= 1'b1;
                        last_reg    <= 1'b0;
                        decrypt_reg <= decrypt_in;
                        parity_reg  <= parity_err;
                    end
                end
                RUN: begin
                    if (advance) begin
                        if (round_reg == 4'd15) begin
                            state_reg <= IDLE;
                            valid_reg <= 1'b0;
                            last_reg  <= 1'b0;
                        end else begin
                            round_reg  <= round_reg + 4'd1;
                            subkey_reg <= subkey_next;
                            last_reg   <= (round_reg == 4'd14);
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign key_in_ready     = (state_reg == IDLE);
    assign subkey_out       = subkey_reg;
    assign subkey_out_valid = valid_reg;
    assign subkey_round_out = round_reg;
    assign subkey_last_out  = last_reg;
    assign parity_err_out   = parity_reg;

endmodule

// File: tb/tb_des_key_sched.sv
// Directed bench for des_key_sched using the classic 133457799BBCDFF1 schedule;
// a second instance has the parity check disabled.
module tb_des_key_sched;

    logic        clk_in = 1'b0;
    logic        rst_n_in;
    logic [63:0] key_in;
    logic        key_in_valid;
    logic        decrypt_in;
    logic        key_in_ready;
    logic [47:0] subkey_out;
    logic        subkey_out_valid;
    logic        subkey_out_ready;
    logic [3:0]  subkey_round_out;
    logic        subkey_last_out;
    logic        parity_err_out;

    logic        key_in_ready_np;
    logic [47:0] subkey_out_np;
    logic        subkey_out_valid_np;
    logic [3:0]  subkey_round_out_np;
    logic        subkey_last_out_np;
    logic        parity_err_out_np;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [63:0] KEY_A = 64'h133457799BBCDFF1;
    localparam logic [63:0] KEY_B = 64'h133457799BBCDFF0;

    // K1..K16 for KEY_A, FIPS order (first hex digit MSB = first DES bit).
    logic [47:0] ks_fips [16] = '{
        48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
        48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
        48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
        48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
    };

    logic [54:0] obs, obs_np, expv;

    always #5 clk_in = ~clk_in;

    des_key_sched #(.CHECK_PARITY(1'b1)) dut (
        .clk_in           (clk_in),
        .rst_n_in         (rst_n_in),
        .key_in           (key_in),
        .key_in_valid     (key_in_valid),
        .decrypt_in       (decrypt_in),
        .key_in_ready     (key_in_ready),
        .subkey_out       (subkey_out),
        .subkey_out_valid (subkey_out_valid),
        .subkey_out_ready (subkey_out_ready),
        .subkey_round_out (subkey_round_out),
        .subkey_last_out  (subkey_last_out),
        .parity_err_out   (parity_err_out)
    );

    des_key_sched #(.CHECK_PARITY(1'b0)) dut_np (
        .clk_in           (clk_in),
        .rst_n_in         (rst_n_in),
        .key_in           (key_in),
        .key_in_valid     (key_in_valid),
        .decrypt_in       (decrypt_in),
        .key_in_ready     (key_in_ready_np),
        .subkey_out       (subkey_out_np),
        .subkey_out_valid (subkey_out_valid_np),
        .subkey_out_ready (subkey_out_ready),
        .subkey_round_out (subkey_round_out_np),
        .subkey_last_out  (subkey_last_out_np),
        .parity_err_out   (parity_err_out_np)
    );

    assign obs    = {key_in_ready, subkey_out_valid, subkey_last_out, subkey_round_out, subkey_out};
    assign obs_np = {key_in_ready_np, subkey_out_valid_np, subkey_last_out_np,
                     subkey_round_out_np, subkey_out_np};

    function automatic logic [63:0] rev64(input logic [63:0] x);
        logic [63:0] r;
        for (int b = 0; b < 64; b++) r[b] = x[63-b];
        return r;
    endfunction

    function automatic logic [47:0] rev48(input logic [47:0] x);
        logic [47:0] r;
        for (int b = 0; b < 48; b++) r[b] = x[47-b];
        return r;
    endfunction

    // Expected in-run view: ready 0, valid 1, last on index 15.
    function automatic logic [54:0] run_view(input int idx, input int k);
        return {1'b0, 1'b1, (idx == 15), 4'(idx), rev48(ks_fips[k])};
    endfunction

    // Offer a key for one edge; returns at the negedge where index 0 is presented.
    task automatic drive_key(input logic [63:0] k, input logic dec);
        @(negedge clk_in);
        key_in       = rev64(k);
        decrypt_in   = dec;
        key_in_valid = 1'b1;
        @(negedge clk_in);
        key_in_valid = 1'b0;
        decrypt_in   = 1'b0;
    endtask

    task automatic test_reset();
        rst_n_in         = 1'b0;
        key_in           = '0;
        key_in_valid     = 1'b0;
        decrypt_in       = 1'b0;
        subkey_out_ready = 1'b1;
        repeat (2) @(negedge clk_in);
        n_checks++;
        if (obs !== {1'b1, 54'h0}) begin
            n_fail++;
            $display("FAIL reset_state: got %h expected %h", obs, {1'b1, 54'h0});
        end
        n_checks++;
        if (parity_err_out !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_parity: got %b expected 0", parity_err_out);
        end
        rst_n_in = 1'b1;
        @(negedge clk_in);
        n_checks++;
        if (obs !== {1'b1, 54'h0}) begin
            n_fail++;
            $display("FAIL post_reset_idle: got %h expected %h", obs, {1'b1, 54'h0});
        end
        $display("reset: idle state checked");
    endtask

    task automatic test_encrypt();
        drive_key(KEY_A, 1'b0);
        for (int i = 0; i < 16; i++) begin
            expv = run_view(i, i);
            n_checks++;
            if (obs !== expv) begin
                n_fail++;
                $display("FAIL enc_seq idx %0d: got %h expected %h", i, obs, expv);
            end
            @(negedge clk_in);
        end
        n_checks++;
        if ({key_in_ready, subkey_out_valid, subkey_last_out, parity_err_out} !== 4'b1000) begin
            n_fail++;
            $display("FAIL enc_end: got rdy/vld/last/par %b expected 1000",
                     {key_in_ready, subkey_out_valid, subkey_last_out, parity_err_out});
        end
        $display("encrypt: key %h, 16 subkeys K1..K16 checked", KEY_A);
    endtask

    task automatic test_decrypt();
        drive_key(KEY_A, 1'b1);
        for (int i = 0; i < 16; i++) begin
            expv = run_view(i, 15 - i);
            n_checks++;
            if (obs !== expv) begin
                n_fail++;
                $display("FAIL dec_seq idx %0d: got %h expected %h", i, obs, expv);
            end
            @(negedge clk_in);
        end
        n_checks++;
        if ({key_in_ready, subkey_out_valid} !== 2'b10) begin
            n_fail++;
            $display("FAIL dec_end: got rdy/vld %b expected 10", {key_in_ready, subkey_out_valid});
        end
        $display("decrypt: key %h, 16 subkeys K16..K1 checked", KEY_A);
    endtask

    task automatic test_backpressure();
        drive_key(KEY_A, 1'b0);
        for (int i = 0; i < 16; i++) begin
            expv = run_view(i, i);
            n_checks++;
            if (obs !== expv) begin
                n_fail++;
                $display("FAIL bp_seq idx %0d: got %h expected %h", i, obs, expv);
            end
            if (i == 4) begin
                subkey_out_ready = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    @(negedge clk_in);
                    n_checks++;
                    if (obs !== expv) begin
                        n_fail++;
                        $display("FAIL bp_hold stall %0d: got %h expected %h", s, obs, expv);
                    end
                end
                subkey_out_ready = 1'b1;
            end
            @(negedge clk_in);
        end
        $display("backpressure: 3-cycle stall at index 4 checked");
    endtask

    task automatic test_parity();
        drive_key(KEY_B, 1'b0);
        n_checks++;
        if ({parity_err_out, parity_err_out_np} !== 2'b10) begin
            n_fail++;
            $display("FAIL parity_flag: got chk/nochk %b expected 10",
                     {parity_err_out, parity_err_out_np});
        end
        for (int i = 0; i < 16; i++) begin
            expv = run_view(i, i);
            n_checks++;
            if (obs !== expv) begin
                n_fail++;
                $display("FAIL parity_seq idx %0d: got %h expected %h", i, obs, expv);
            end
            n_checks++;
            if (obs_np !== expv) begin
                n_fail++;
                $display("FAIL parity_seq_np idx %0d: got %h expected %h", i, obs_np, expv);
            end
            @(negedge clk_in);
        end
        n_checks++;
        if (parity_err_out !== 1'b1) begin
            n_fail++;
            $display("FAIL parity_hold: got %b expected 1", parity_err_out);
        end
        $display("parity: key %h flagged, subkeys unchanged", KEY_B);
    endtask

    task automatic test_busy_back_to_back();
        drive_key(KEY_A, 1'b0);
        for (int i = 0; i < 16; i++) begin
            expv = run_view(i, i);
            n_checks++;
            if (obs !== expv) begin
                n_fail++;
                $display("FAIL busy_seq idx %0d: got %h expected %h", i, obs, expv);
            end
            if (i == 2) begin
                key_in       = rev64(KEY_B);
                decrypt_in   = 1'b1;
                key_in_valid = 1'b1;
            end else if (i == 3) begin
                key_in_valid = 1'b0;
                decrypt_in   = 1'b0;
            end else if (i == 15) begin
                key_in       = rev64(KEY_A);
                decrypt_in   = 1'b1;
                key_in_valid = 1'b1;
            end
            @(negedge clk_in);
        end
        // Key was held through the last handshake edge: idle now, not yet accepted.
        n_checks++;
        if ({key_in_ready, subkey_out_valid, parity_err_out} !== 3'b100) begin
            n_fail++;
            $display("FAIL b2b_gap: got rdy/vld/par %b expected 100",
                     {key_in_ready, subkey_out_valid, parity_err_out});
        end
        @(negedge clk_in);
        key_in_valid = 1'b0;
        decrypt_in   = 1'b0;
        for (int i = 0; i < 16; i++) begin
            expv = run_view(i, 15 - i);
            n_checks++;
            if (obs !== expv) begin
                n_fail++;
                $display("FAIL b2b_seq idx %0d: got %h expected %h", i, obs, expv);
            end
            @(negedge clk_in);
        end
        $display("busy: RUN-time key ignored, follow-on decrypt key sequenced");
    endtask

    task automatic test_reset_mid_run();
        drive_key(KEY_A, 1'b0);
        repeat (7) @(negedge clk_in);
        expv = run_view(7, 7);
        n_checks++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL rst_mid_pre: got %h expected %h", obs, expv);
        end
        #2 rst_n_in = 1'b0;
        #1;
        n_checks++;
        if (obs !== {1'b1, 54'h0}) begin
            n_fail++;
            $display("FAIL rst_mid_async: got %h expected %h", obs, {1'b1, 54'h0});
        end
        @(negedge clk_in);
        rst_n_in = 1'b1;
        drive_key(KEY_A, 1'b1);
        for (int i = 0; i < 4; i++) begin
            expv = run_view(i, 15 - i);
            n_checks++;
            if (obs !== expv) begin
                n_fail++;
                $display("FAIL rst_restart idx %0d: got %h expected %h", i, obs, expv);
            end
            @(negedge clk_in);
        end
        $display("reset mid-run: abandoned at index 7, restart from index 0 checked");
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish within 100000 time units");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_encrypt();
        test_decrypt();
        test_backpressure();
        test_parity();
        test_busy_back_to_back();
        test_reset_mid_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
